// File: rtl/ram_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ram_ctrl_pkg
// Shared definitions for the two-requester RAM access arbiter:
//   state_t      - controller states (IDLE, CMD, WAIT)
//   REQ0 / REQ1  - requester indices into the 2-bit request/grant vectors
//   CNT_W        - width of the read-latency countdown (RD_LAT up to 15)
//   idx2onehot   - turns a requester index into its one-hot vector
// ----------------------------------------------------------------------------
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned REQ0    = 0;
    localparam int unsigned REQ1    = 1;
    localparam int unsigned CNT_W   = 4;

    function automatic logic [NUM_REQ-1:0] idx2onehot(input logic idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/ram_access_arb_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin selector, purely combinational.
//   req_i [1:0] : request vector
//   ptr_i       : requester that wins when both are requesting
//   win_o [1:0] : one-hot winner, all zero when nobody requests
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] win_o
);

    // A lone requester always wins; the pointer only breaks a tie.
    always_comb begin
        win_o = req_i;
        if (req_i == 2'b11) begin
            win_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ram_access_arb.sv
// ----------------------------------------------------------------------------
// ram_access_arb
// Arbitrates two requesters onto a single-port RAM with fixed read latency.
// One operation is in flight at a time: a write occupies IDLE+CMD, a read
// occupies IDLE+CMD+RD_LAT WAIT cycles. Every output comes from a flop.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_req, i_we             : per-requester request valid and op type (1=write)
//   i_addr0/1, i_wdata0/1   : per-requester address and write data
//   o_gnt                   : one-hot accept pulse, high during the CMD cycle
//   o_rvalid, o_rdata       : one-hot read-valid pulse and captured read data
//   o_ram_rd_en/o_ram_wr_en : RAM command strobes (CMD cycle only)
//   o_ram_addr/o_ram_wdata  : RAM address/data, held between commands
//   i_ram_rdata             : RAM read data, valid RD_LAT cycles after rd_en
// ----------------------------------------------------------------------------
module ram_access_arb
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned SIZE_ADDR = 8,
    parameter int unsigned SIZE_DATA = 8,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [1:0]           i_req,
    input  logic [1:0]           i_we,
    input  logic [SIZE_ADDR-1:0] i_addr0,
    input  logic [SIZE_ADDR-1:0] i_addr1,
    input  logic [SIZE_DATA-1:0] i_wdata0,
    input  logic [SIZE_DATA-1:0] i_wdata1,
    output logic [1:0]           o_gnt,
    output logic [1:0]           o_rvalid,
    output logic [SIZE_DATA-1:0] o_rdata,
    output logic                 o_ram_rd_en,
    output logic                 o_ram_wr_en,
    output logic [SIZE_ADDR-1:0] o_ram_addr,
    output logic [SIZE_DATA-1:0] o_ram_wdata,
    input  logic [SIZE_DATA-1:0] i_ram_rdata
);

    // The CMD cycle already accounts for one cycle of read latency.
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);

    state_t               state_q;
    logic                 ptr_q;
    logic                 owner_q;
    logic                 we_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [1:0]           gnt_q;
    logic [1:0]           rvalid_q;
    logic [SIZE_DATA-1:0] rdata_q;
    logic                 rd_en_q;
    logic                 wr_en_q;
    logic [SIZE_ADDR-1:0] addr_q;
    logic [SIZE_DATA-1:0] wdata_q;

    logic [1:0]           win_d;
    logic                 winIdx_d;

    rr_arb2 u_rr_arb2 (
        .req_i (i_req),
        .ptr_i (ptr_q),
        .win_o (win_d)
    );

    assign winIdx_d = win_d[REQ1];

    // The address/data registers double as the request latch, so they feed
    // the RAM directly and naturally hold their value outside CMD. Pulsed
    // outputs default low every cycle and are raised only in their state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|i_req) begin
                        owner_q <= winIdx_d;
                        we_q    <= i_we[winIdx_d];
                        ptr_q   <= ~winIdx_d;
                        gnt_q   <= win_d;
                        addr_q  <= winIdx_d ? i_addr1  : i_addr0;
                        wdata_q <= winIdx_d ? i_wdata1 : i_wdata0;
                        wr_en_q <= i_we[winIdx_d];
                        rd_en_q <= ~i_we[winIdx_d];
                        state_q <= CMD;
                    end
                end
                CMD: begin
                    if (we_q) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= LAT_LOAD;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        rdata_q  <= i_ram_rdata;
                        rvalid_q <= idx2onehot(owner_q);
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_gnt       = gnt_q;
    assign o_rvalid    = rvalid_q;
    assign o_rdata     = rdata_q;
    assign o_ram_rd_en = rd_en_q;
    assign o_ram_wr_en = wr_en_q;
    assign o_ram_addr  = addr_q;
    assign o_ram_wdata = wdata_q;

endmodule

// File: doc/ram_access_arb.md
RAM_ACCESS_ARB -- requirements
Module: ram_access_arb

Interface
REQ-001 SHALL have parameter SIZE_ADDR, default 8, RAM address width.
REQ-002 SHALL have parameter SIZE_DATA, default 8, RAM data width.
REQ-003 SHALL have parameter RD_LAT, default 2, cycles from o_ram_rd_en to valid i_ram_rdata (range 1..15).
REQ-004 SHALL have one clock, i_clk  input  1  rising-edge clock.
REQ-005 SHALL have reset i_rst_n  input  1  asynchronous, active-low.
REQ-006 SHALL have i_req  input  2  per-requester request valid, held until granted.
REQ-007 SHALL have i_we  input  2  per-requester op type, 1=write, 0=read.
REQ-008 SHALL have i_addr0, i_addr1  input  SIZE_ADDR  requester addresses.
REQ-009 SHALL have i_wdata0, i_wdata1  input  SIZE_DATA  requester write data.
REQ-010 SHALL have o_gnt  output  2  one-hot, one-cycle accept pulse.
REQ-011 SHALL have o_rvalid  output  2  one-hot, one-cycle read-data-valid pulse to read owner.
REQ-012 SHALL have o_rdata  output  SIZE_DATA  captured read data, held until next capture.
REQ-013 SHALL have o_ram_rd_en, o_ram_wr_en  output  1  RAM command strobes.
REQ-014 SHALL have o_ram_addr  output  SIZE_ADDR; o_ram_wdata  output  SIZE_DATA; i_ram_rdata  input  SIZE_DATA.

Function
REQ-015 SHALL implement FSM states IDLE, CMD, WAIT; all outputs registered.
REQ-016 IDLE: if any i_req bit set, SHALL select winner, latch its we/addr/wdata, go to CMD next edge; else stay IDLE.
REQ-017 Arbitration SHALL be round-robin: single requester wins; both requesting -> pointer holder wins; pointer then moves to the other requester.
REQ-018 CMD (exactly one cycle): SHALL assert o_gnt[winner], o_ram_addr/o_ram_wdata from latch, and o_ram_wr_en (write) or o_ram_rd_en (read), never both.
REQ-019 CMD write SHALL return to IDLE; CMD read SHALL load counter with RD_LAT-1 and enter WAIT.
REQ-020 WAIT SHALL decrement counter each cycle; on counter==0 SHALL capture i_ram_rdata into o_rdata, pulse o_rvalid[owner] next cycle, return to IDLE.
REQ-021 Read data SHALL be sampled exactly RD_LAT cycles after the o_ram_rd_en cycle.
REQ-022 Requests arriving in CMD/WAIT SHALL be held off (no grant) and arbitrated on return to IDLE.
REQ-023 Strobes and o_gnt SHALL be 0 outside CMD; o_ram_addr/o_ram_wdata SHALL hold last values outside CMD.
REQ-024 Throughput: write 2 cycles/op; read RD_LAT+2 cycles/op; no back-to-back overlap.
REQ-025 Requester deasserting i_req before grant while in IDLE SHALL never be granted that op.

Reset
REQ-026 On i_rst_n low, at any time: state IDLE, pointer=0, counter=0, all outputs 0.
REQ-027 Reset during WAIT SHALL drop the pending read; no o_rvalid after reset release.
REQ-028 First edge after release with i_req=2'b11 SHALL grant requester 0.

Structure
REQ-029 State enum and requester index constants SHALL live in shared package ram_ctrl_pkg.
REQ-030 Round-robin selector SHALL be a sub-module rr_arb2 (req, ptr -> one-hot win).
REQ-031 RAM command outputs SHALL drive the existing registered RAM address stage directly.

Verification
REQ-032 Req0 write addr=0x10 data=0xA5 alone -> CMD cycle: o_gnt=01, o_ram_wr_en=1, o_ram_addr=0x10, o_ram_wdata=0xA5; IDLE next.
REQ-033 Req1 read addr=0x10, RAM model returns 0xA5 at RD_LAT=2 -> o_rvalid=10, o_rdata=0xA5 RD_LAT+1 cycles after o_gnt.
REQ-034 i_req=11 held for four ops, all writes -> grant order 01,10,01,10.
REQ-035 Req0 read in WAIT while req1 asserts write -> req1 o_gnt only after o_rvalid[0], never during WAIT.
REQ-036 Reset asserted mid-WAIT -> outputs 0 immediately, no o_rvalid after release; i_req=11 then grants 01.
REQ-037 RD_LAT=1 and RD_LAT=15 rebuilds -> read data captured at exact latency, strobes never overlap.
